debounce: RTL and testbench
===========================

DEBOUNCE -- requirements
Module: debounce

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 16, which is the number of consecutive equal synchronised samples needed to accept a new level; legal range 2..65535.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port din, input, 1 bit: raw level, asynchronous to clk and possibly bouncing.
REQ-005 The block SHALL have port dout, output, 1 bit: debounced level, registered, intended to feed the downstream edge/pulse generator's d input.
REQ-006 The block SHALL have port busy, output, 1 bit: registered; high while a candidate level change is being qualified.

Function
REQ-007 din SHALL pass through a 2-flop synchroniser; only the second-stage output (sync) is used by the rest of the block.
REQ-008 The FSM SHALL have four states: ST_LO, CHK_HI, ST_HI, CHK_LO.
REQ-009 In ST_LO (dout=0) with sync=1, the FSM SHALL go to CHK_HI with cnt<=1; with sync=0 it SHALL stay.
REQ-010 In CHK_HI with sync=0, the FSM SHALL return to ST_LO with cnt<=0 and dout unchanged (0).
REQ-011 In CHK_HI with sync=1 and cnt<DB_CYCLES-1, it SHALL do cnt<=cnt+1 and stay.
REQ-012 In CHK_HI with sync=1 and cnt==DB_CYCLES-1, it SHALL go to ST_HI with dout<=1 and cnt<=0.
REQ-013 ST_HI and CHK_LO SHALL mirror REQ-009..012 with levels inverted; dout<=0 on entry to ST_LO from CHK_LO.
REQ-014 Latency: if din is stable at a new level from before edge k, dout SHALL show that level after edge k+1+DB_CYCLES, and not earlier.
REQ-015 Any opposite sync sample during CHK_* SHALL abort the qualification; a later attempt SHALL restart the count from 1. Counts SHALL never accumulate across aborts.
REQ-016 busy SHALL be 1 exactly when the registered state is CHK_HI or CHK_LO.
REQ-017 dout SHALL change only on the ST_* entry edges of REQ-012/013, at most once per qualification, and never while sync equals dout.
REQ-018 cnt width SHALL be $clog2(DB_CYCLES); cnt SHALL never exceed DB_CYCLES-1 and SHALL never wrap.
REQ-019 dout and busy SHALL come straight from flops with no combinational path from din.

Reset
REQ-020 On rst_n=0, without waiting for a clock edge: both synchroniser flops SHALL be 0, state ST_LO, cnt 0, dout 0, busy 0.
REQ-021 Reset asserted mid-qualification SHALL discard the partial count; after release, any change needs a full DB_CYCLES qualification.
REQ-022 After rst_n deasserts, the first state update SHALL occur at the next rising clk edge.

Structure
REQ-023 State encodings (2-bit localparams ST_LO/CHK_HI/ST_HI/CHK_LO) SHALL live in shared package db_pkg, which the testbench reuses for state checks.
REQ-024 The synchroniser SHALL be a separate sub-module, sync2 (clk, rst_n, d, q; reset value 0), reusable by other blocks.
REQ-025 The FSM and counter SHALL be in debounce itself; expected RTL size is 120-200 lines.

Verification (DB_CYCLES=4)
REQ-026 Reset: hold rst_n=0 with din toggling -> dout=0, busy=0 throughout; release -> still 0 until a qualified change.
REQ-027 Clean rise: din 0->1 before edge 10, held -> busy=1 after edges 12..14, dout=1 after edge 15 and not after edge 14, busy=0 after edge 15.
REQ-028 Glitch: din high for 3 cycles (before edges 10..12) then low -> dout stays 0, busy=1 then back to 0, no dout change.
REQ-029 Clean fall from dout=1: din 1->0 before edge 30 -> dout=0 after edge 35.
REQ-030 Chatter: din toggling every cycle for 50 cycles -> dout never changes; then hold 1 -> dout=1 exactly 5 edges after the hold begins.
REQ-031 Reset mid-CHK_HI (after edge 13 of REQ-027): rst_n low 2 cycles -> dout=0 and busy=0 immediately; din still 1 after release -> dout=1 only after a full 2+4-edge re-qualification.

Source files
------------

// File: rtl/db_pkg.sv
// Shared definitions for the debounce block: FSM state encodings and a helper
// that classifies qualifying states.
package db_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_LO  = 2'd0;
    localparam state_t CHK_HI = 2'd1;
    localparam state_t ST_HI  = 2'd2;
    localparam state_t CHK_LO = 2'd3;

    function automatic logic isCheck(input state_t s);
        return (s == CHK_HI) || (s == CHK_LO);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous level; resets to 0.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/debounce.sv
// Debouncer: a new synchronised level must persist for DB_CYCLES consecutive
// samples before dout follows it; busy flags an in-progress qualification.
module debounce
    import db_pkg::*;
#(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic busy
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic          sync;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dout_q, dout_d;
    logic          busy_q, busy_d;

    sync2 u_sync2 (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (din),
        .q    (sync)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LO;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
        end
    end

    // An opposite sample in a CHK state aborts and clears the count, so
    // partial qualifications never accumulate.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_LO: begin
                if (sync) begin
                    state_d = CHK_HI;
                    cnt_d   = CNT_ONE;
                end
            end
            CHK_HI: begin
                if (!sync) begin
                    state_d = ST_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HI: begin
                if (!sync) begin
                    state_d = CHK_LO;
                    cnt_d   = CNT_ONE;
                end
            end
            CHK_LO: begin
                if (sync) begin
                    state_d = ST_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_LO;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the flops track state_q exactly.
    always_comb begin
        dout_d = (state_d == ST_HI) || (state_d == CHK_LO);
        busy_d = isCheck(state_d);
    end

    assign dout = dout_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_debounce.sv
// Directed bench for debounce with DB_CYCLES=4; edge e1 is the first rising
// edge after din is changed, so a clean change lands on dout at e6.
module tb_debounce;
    import db_pkg::*;

    localparam int DB = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic din;
    logic dout;
    logic busy;

    int testsRun  = 0;
    int failCount = 0;

    debounce #(.DB_CYCLES(DB)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (din),
        .dout (dout),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic d, input logic r);
        din   = d;
        rst_n = r;
    endtask

    task automatic checkOutput(input string tag, input logic [1:0] observed, input logic [1:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic expDout, input logic expBusy);
        state_t expState;
        expState = expBusy ? (expDout ? CHK_LO : CHK_HI) : (expDout ? ST_HI : ST_LO);
        checkOutput({tag, "_dout"}, {1'b0, dout}, {1'b0, expDout});
        checkOutput({tag, "_busy"}, {1'b0, busy}, {1'b0, expBusy});
        checkOutput({tag, "_state"}, dut.state_q, expState);
    endtask

    // Checks edges eFirst..eLast: busy within [busyFrom,busyTo], dout flips at doutEdge.
    task automatic runEdges(input string tag, input int eFirst, input int eLast,
                            input int busyFrom, input int busyTo,
                            input int doutEdge, input logic doutInit);
        for (int e = eFirst; e <= eLast; e++) begin
            tick();
            checkAll($sformatf("%s_e%0d", tag, e),
                     (e >= doutEdge) ? ~doutInit : doutInit,
                     (e >= busyFrom) && (e <= busyTo));
        end
    endtask

    initial begin
        applyStimulus(1'b0, 1'b1);
        #2;
        applyStimulus(1'b0, 1'b0);
        #1;
        checkAll("rstAsync", 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(logic'(i % 2 == 0), 1'b0);
            tick();
            checkAll($sformatf("rstHold%0d", i), 1'b0, 1'b0);
        end

        applyStimulus(1'b0, 1'b1);
        runEdges("idle", 1, 5, 99, 0, 99, 1'b0);

        applyStimulus(1'b1, 1'b1);
        runEdges("rise", 1, 8, 3, 5, 6, 1'b0);

        applyStimulus(1'b0, 1'b1);
        runEdges("glitchLo", 1, 3, 3, 5, 99, 1'b1);
        applyStimulus(1'b1, 1'b1);
        runEdges("glitchLo", 4, 8, 3, 5, 99, 1'b1);

        applyStimulus(1'b0, 1'b1);
        runEdges("fall", 1, 8, 3, 5, 6, 1'b1);

        applyStimulus(1'b1, 1'b1);
        runEdges("glitchHi", 1, 3, 3, 5, 99, 1'b0);
        applyStimulus(1'b0, 1'b1);
        runEdges("glitchHi", 4, 8, 3, 5, 99, 1'b0);

        // One low sample mid-qualification forces a full restart of the count.
        applyStimulus(1'b1, 1'b1);
        runEdges("abort", 1, 2, 3, 4, 99, 1'b0);
        applyStimulus(1'b0, 1'b1);
        runEdges("abort", 3, 3, 3, 4, 99, 1'b0);
        applyStimulus(1'b1, 1'b1);
        runEdges("abort", 4, 5, 3, 4, 99, 1'b0);
        runEdges("abort", 6, 10, 6, 8, 9, 1'b0);

        applyStimulus(1'b0, 1'b1);
        runEdges("fall2", 1, 8, 3, 5, 6, 1'b1);

        for (int i = 0; i < 50; i++) begin
            applyStimulus(logic'(i % 2 == 0), 1'b1);
            tick();
            checkOutput($sformatf("chatter%0d_dout", i), {1'b0, dout}, 2'b00);
        end
        applyStimulus(1'b1, 1'b1);
        runEdges("chatHold", 1, 1, 1, 1, 99, 1'b0);
        runEdges("chatHold", 2, 2, 99, 0, 99, 1'b0);
        runEdges("chatHold", 3, 8, 3, 5, 6, 1'b0);

        applyStimulus(1'b0, 1'b1);
        runEdges("fall3", 1, 8, 3, 5, 6, 1'b1);

        applyStimulus(1'b1, 1'b1);
        runEdges("rstMid", 1, 4, 3, 5, 99, 1'b0);
        applyStimulus(1'b1, 1'b0);
        #1;
        checkAll("rstMidAsync", 1'b0, 1'b0);
        tick();
        checkAll("rstMidHold1", 1'b0, 1'b0);
        tick();
        checkAll("rstMidHold2", 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1);
        runEdges("requal", 1, 8, 3, 5, 6, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
